// File: rtl/fetch_fd.sv
// Fetch stage PC register plus the F->D pipeline register.
// Holds PC_F, and captures PC/instruction/fetch-exception/delay-slot state into D.
// Optional feature: define FETCH_ADDR_CHECK_EN to flag misaligned or
// out-of-range fetches with ExcCode_D = 4 (AdEL) and squash the instruction.
module fetch_fd (
  input  logic        clk,
  input  logic        reset,
  input  logic        stopen,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic        is_jb_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned EXC_W    = 5;
  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [XLEN-1:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [XLEN-1:0] IM_LO      = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_HI      = 32'h0000_6FFC;
  localparam logic [EXC_W-1:0] EXC_NONE  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL  = 5'd4;

  logic [XLEN-1:0]  r_pc_f;
  logic [XLEN-1:0]  r_pc_d;
  logic [XLEN-1:0]  r_instr_d;
  logic [EXC_W-1:0] r_exc_d;
  logic             r_bd_d;

  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_npc;
  logic             w_fetch_bad;
  logic [XLEN-1:0]  w_instr_adv;
  logic [EXC_W-1:0] w_exc_adv;

  // Sequential next PC; reserved select falls back to PC+4, wrap is natural.
  always_comb begin
    w_pc_plus4 = XLEN'(r_pc_f + 32'd4);
    w_npc      = w_pc_plus4;
    case (npc_sel)
      2'd1:    w_npc = br_target;
      2'd2:    w_npc = j_target;
      default: w_npc = w_pc_plus4;
    endcase
  end

  // Fetch address check: classify the current PC_F and pick what D captures.
  always_comb begin
    w_fetch_bad = 1'b0;
    w_instr_adv = instr_F;
    w_exc_adv   = EXC_NONE;
`ifdef FETCH_ADDR_CHECK_EN
    w_fetch_bad = (r_pc_f[1:0] != 2'b00) || (r_pc_f < IM_LO) || (r_pc_f > IM_HI);
    if (w_fetch_bad) begin
      w_instr_adv = '0;
      w_exc_adv   = EXC_ADEL;
    end
`else
    w_fetch_bad = 1'b0;
`endif
  end

  // PC and D-stage registers: reset > exception > eret > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f    <= RESET_PC;
      r_pc_d    <= RESET_PC;
      r_instr_d <= '0;
      r_exc_d   <= EXC_NONE;
      r_bd_d    <= 1'b0;
    end else if (exc_req) begin
      r_pc_f    <= HANDLER_PC;
      r_pc_d    <= HANDLER_PC;
      r_instr_d <= '0;
      r_exc_d   <= EXC_NONE;
      r_bd_d    <= 1'b0;
    end else if (eret_req) begin
      r_pc_f    <= epc_in;
      r_pc_d    <= epc_in;
      r_instr_d <= '0;
      r_exc_d   <= EXC_NONE;
      r_bd_d    <= 1'b0;
    end else if (!stopen) begin
      r_pc_f    <= w_npc;
      r_pc_d    <= r_pc_f;
      r_instr_d <= w_instr_adv;
      r_exc_d   <= w_exc_adv;
      r_bd_d    <= is_jb_D;
    end
  end

  assign PC_F      = r_pc_f;
  assign PC_D      = r_pc_d;
  assign Instr_D   = r_instr_d;
  assign ExcCode_D = r_exc_d;
  assign BD_D      = r_bd_d;

endmodule
